// File: rtl/mips32_mem_pkg.sv
// Shared parameters and grant encoding for the MIPS32 memory responder and the core.
package mips32_mem_pkg;

  localparam int ADDR_W   = 10;
  localparam int DATA_W   = 32;
  localparam int DEPTH    = 2 ** ADDR_W;
  localparam int FAIR_LIM = 4;
  localparam int FAIR_W   = $clog2(FAIR_LIM + 1);

  typedef enum logic [1:0] {
    GNT_NONE,
    GNT_I,
    GNT_D
  } grant_e;

endpackage

// File: rtl/mips32_mem_arbiter.sv
// Single-access-per-cycle arbiter: data port has priority, instruction port is
// protected from starvation by a consecutive-data-grant counter.
module mips32_mem_arbiter
  import mips32_mem_pkg::*;
(
  input  logic   clk,
  input  logic   rst_n,
  input  logic   i_ireq_valid,
  input  logic   i_irsp_valid,
  input  logic   i_irsp_ready,
  input  logic   i_dreq_valid,
  input  logic   i_dreq_we,
  input  logic   i_drsp_valid,
  input  logic   i_drsp_ready,
  output logic   o_ireq_ready,
  output logic   o_dreq_ready,
  output grant_e o_grant
);

  logic              w_i_elig;
  logic              w_d_elig;
  logic              w_fair_hit;
  logic [FAIR_W-1:0] r_fair_cnt;
  logic [FAIR_W-1:0] w_fair_nxt;
  grant_e            w_grant;

  // Stores never occupy the response slot, so they are eligible regardless of it.
  assign w_i_elig   = i_ireq_valid && (!i_irsp_valid || i_irsp_ready);
  assign w_d_elig   = i_dreq_valid && (i_dreq_we || !i_drsp_valid || i_drsp_ready);
  assign w_fair_hit = (r_fair_cnt == FAIR_W'(FAIR_LIM));

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    w_grant = GNT_NONE;
    if (!rst_n) begin
      w_grant = GNT_NONE;
    end else if (w_d_elig && !(w_i_elig && w_fair_hit)) begin
      w_grant = GNT_D;
    end else if (w_i_elig) begin
      w_grant = GNT_I;
    end
  end

  always_comb begin
    w_fair_nxt = r_fair_cnt;
    if (!i_ireq_valid || w_grant == GNT_I) begin
      w_fair_nxt = '0;
    end else if (w_grant == GNT_D && !w_fair_hit) begin
      w_fair_nxt = r_fair_cnt + 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fair_cnt <= '0;
    end else begin
      r_fair_cnt <= w_fair_nxt;
    end
  end

  assign o_grant      = w_grant;
  assign o_ireq_ready = (w_grant == GNT_I);
  assign o_dreq_ready = (w_grant == GNT_D);

endmodule

// File: rtl/mips32_mem_responder.sv
// Memory-side responder for the MIPS32 core: single-ported word array serving an
// instruction fetch port and a load/store port with one-cycle read latency.
module mips32_mem_responder
  import mips32_mem_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_req_valid,
  output logic              i_req_ready,
  input  logic [ADDR_W-1:0] i_req_addr,
  output logic              i_rsp_valid,
  input  logic              i_rsp_ready,
  output logic [DATA_W-1:0] i_rsp_data,
  input  logic              d_req_valid,
  output logic              d_req_ready,
  input  logic              d_req_we,
  input  logic [ADDR_W-1:0] d_req_addr,
  input  logic [DATA_W-1:0] d_req_wdata,
  output logic              d_rsp_valid,
  input  logic              d_rsp_ready,
  output logic [DATA_W-1:0] d_rsp_data
);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic              r_i_valid;
  logic [DATA_W-1:0] r_i_data;
  logic              r_d_valid;
  logic [DATA_W-1:0] r_d_data;
  grant_e            w_grant;
  logic              w_i_rd;
  logic              w_d_rd;
  logic              w_d_wr;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_rd_data;

  mips32_mem_arbiter u_arb (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_ireq_valid (i_req_valid),
    .i_irsp_valid (r_i_valid),
    .i_irsp_ready (i_rsp_ready),
    .i_dreq_valid (d_req_valid),
    .i_dreq_we    (d_req_we),
    .i_drsp_valid (r_d_valid),
    .i_drsp_ready (d_rsp_ready),
    .o_ireq_ready (i_req_ready),
    .o_dreq_ready (d_req_ready),
    .o_grant      (w_grant)
  );

  assign w_i_rd    = (w_grant == GNT_I);
  assign w_d_rd    = (w_grant == GNT_D) && !d_req_we;
  assign w_d_wr    = (w_grant == GNT_D) &&  d_req_we;
  assign w_addr    = w_i_rd ? i_req_addr : d_req_addr;
  assign w_rd_data = r_mem[w_addr];

  // NOTE: the storage array has no reset; its contents must survive rst_n.
  always_ff @(posedge clk) begin
    if (w_d_wr) begin
      r_mem[w_addr] <= d_req_wdata;
    end
  end

  // A drain and a new accept on the same edge reloads the slot without a bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_i_valid <= 1'b0;
      r_i_data  <= '0;
      r_d_valid <= 1'b0;
      r_d_data  <= '0;
    end else begin
      if (w_i_rd) begin
        r_i_valid <= 1'b1;
        r_i_data  <= w_rd_data;
      end else if (i_rsp_ready) begin
        r_i_valid <= 1'b0;
        r_i_data  <= '0;
      end
      if (w_d_rd) begin
        r_d_valid <= 1'b1;
        r_d_data  <= w_rd_data;
      end else if (d_rsp_ready) begin
        r_d_valid <= 1'b0;
        r_d_data  <= '0;
      end
    end
  end

  assign i_rsp_valid = r_i_valid;
  assign i_rsp_data  = r_i_data;
  assign d_rsp_valid = r_d_valid;
  assign d_rsp_data  = r_d_data;

endmodule
